// File: rtl/fft_butterfly_sched_if.sv
// fft_butterfly_sched_if
//   Bundles every non-clock/reset signal of the radix-2 FFT sequencer.
//   master : the sequencer side.
//            Drives busy/done/err, the RAM read/write strobes, addresses and
//            write data, the twiddle address, and the butterfly operands.
//   slave  : the environment side.
//            Drives start, the RAM read data, the twiddle data, and the
//            butterfly results.
//   LOG2N must match the LOG2N of the attached fft_butterfly_sched.
interface fft_butterfly_sched_if #(
  parameter int LOG2N = 8
);
  // twiddle address is LOG2N-1 bits, but never narrower than one bit
  localparam int TWW = (LOG2N > 1) ? LOG2N - 1 : 1;

  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [63:0]      rd_data_a;
  logic [63:0]      rd_data_b;
  logic [TWW-1:0]   tw_addr;
  logic [63:0]      tw_data;
  logic             bf_valid_in;
  logic [63:0]      bf_a;
  logic [63:0]      bf_b;
  logic [63:0]      bf_w;
  logic [63:0]      bf_c;
  logic [63:0]      bf_d;
  logic             bf_valid_out;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [63:0]      wr_data_a;
  logic [63:0]      wr_data_b;

  modport master (
    input  start,
    output busy, done, err,
    output rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    output tw_addr,
    input  tw_data,
    output bf_valid_in, bf_a, bf_b, bf_w,
    input  bf_c, bf_d, bf_valid_out,
    output wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

  modport slave (
    output start,
    input  busy, done, err,
    input  rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    input  tw_addr,
    output tw_data,
    input  bf_valid_in, bf_a, bf_b, bf_w,
    output bf_c, bf_d, bf_valid_out,
    input  wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );
endinterface

// File: rtl/fft_butterfly_sched.sv
// fft_butterfly_sched
//   In-place radix-2 DIT FFT sequencer.
//   Walks LOG2N stages of N/2 butterflies over a dual-port sample RAM,
//   feeding one shared butterfly unit with one butterfly outstanding at a
//   time.
//   Input samples are expected in bit-reversed order; the result is in
//   natural order.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : fft_butterfly_sched_if.master, which carries:
//     - start / busy / done / err control
//     - RAM read and write ports
//     - twiddle ROM port
//     - butterfly unit handshake
//
// Configuration:
//   BF_TIMEOUT_EN
//     When defined, EXEC is guarded by a TIMEOUT-cycle watchdog.
//     On expiry the sequencer sets a sticky err and aborts to DONE without
//     writing.
//     Otherwise EXEC waits indefinitely and err is tied low.
module fft_butterfly_sched #(
  parameter int LOG2N   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fft_butterfly_sched_if.master bus
);
  localparam int             TWW    = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int             NHALF  = 1 << (LOG2N - 1);
  localparam logic [TWW-1:0] J_LAST = TWW'(NHALF - 1);
  localparam logic [3:0]     S_LAST = 4'(LOG2N - 1);

  if (LOG2N < 1 || LOG2N > 12 || TIMEOUT < 1) begin : g_param_check
    $error("fft_butterfly_sched: LOG2N must be 1..12 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    EXEC = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_r;
  logic [3:0]       s_r;
  logic [TWW-1:0]   j_r;
  logic [3:0]       s_nxt_s;
  logic [TWW-1:0]   j_nxt_s;
  logic             last_j_s;
  logic             last_s_s;

  logic             busy_r, done_r, rd_en_r, wr_en_r, bf_valid_in_r;
  logic [LOG2N-1:0] rd_addr_a_r, rd_addr_b_r, wr_addr_a_r, wr_addr_b_r;
  logic [TWW-1:0]   tw_addr_r;
  logic [63:0]      bf_a_r, bf_b_r, bf_w_r, wr_data_a_r, wr_data_b_r;

  // k = j & (half-1): position of the butterfly inside its group
  function automatic logic [31:0] bfly_k(input logic [3:0] s, input logic [TWW-1:0] j);
    return 32'(j) & ((32'd1 << s) - 32'd1);
  endfunction

  // upper-wing address: group base (g << (s+1)) plus offset k
  function automatic logic [LOG2N-1:0] addr_a_of(input logic [3:0] s, input logic [TWW-1:0] j);
    logic [31:0] g;
    g = 32'(j) >> s;
    return LOG2N'((g << (s + 4'd1)) | bfly_k(s, j));
  endfunction

  // lower-wing address sits one half-span above the upper wing
  function automatic logic [LOG2N-1:0] addr_b_of(input logic [3:0] s, input logic [TWW-1:0] j);
    return addr_a_of(s, j) + LOG2N'(32'd1 << s);
  endfunction

  // twiddle index scaled so early stages step coarsely through the ROM
  function automatic logic [TWW-1:0] tw_of(input logic [3:0] s, input logic [TWW-1:0] j);
    logic [31:0] t;
    t = bfly_k(s, j) << (4'(LOG2N - 1) - s);
    return TWW'(t);
  endfunction

  // next (stage, butterfly) pair after the current write completes
  always_comb begin
    last_j_s = (j_r == J_LAST);
    last_s_s = (s_r == S_LAST);
    if (!last_j_s) begin
      j_nxt_s = j_r + TWW'(1);
      s_nxt_s = s_r;
    end else begin
      j_nxt_s = '0;
      s_nxt_s = last_s_s ? s_r : s_r + 4'd1;
    end
  end

`ifdef BF_TIMEOUT_EN
  localparam int             TOW     = $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);
  logic [TOW-1:0] to_cnt_r;
  logic           err_r;
`endif

  // sequencer FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      s_r           <= 4'd0;
      j_r           <= '0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      rd_en_r       <= 1'b0;
      wr_en_r       <= 1'b0;
      bf_valid_in_r <= 1'b0;
      rd_addr_a_r   <= '0;
      rd_addr_b_r   <= '0;
      tw_addr_r     <= '0;
      wr_addr_a_r   <= '0;
      wr_addr_b_r   <= '0;
      bf_a_r        <= 64'd0;
      bf_b_r        <= 64'd0;
      bf_w_r        <= 64'd0;
      wr_data_a_r   <= 64'd0;
      wr_data_b_r   <= 64'd0;
`ifdef BF_TIMEOUT_EN
      to_cnt_r      <= '0;
      err_r         <= 1'b0;
`endif
    end else begin
      // strobes are single-cycle unless a state re-asserts them
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      wr_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            s_r         <= 4'd0;
            j_r         <= '0;
            busy_r      <= 1'b1;
            rd_en_r     <= 1'b1;
            rd_addr_a_r <= addr_a_of(4'd0, '0);
            rd_addr_b_r <= addr_b_of(4'd0, '0);
            tw_addr_r   <= tw_of(4'd0, '0);
`ifdef BF_TIMEOUT_EN
            err_r       <= 1'b0;
`endif
            state_r     <= RD;
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          state_r <= CAP;
        end
        CAP: begin
          // RAM and ROM data are valid now, one cycle after the read strobe
          bf_a_r        <= bus.rd_data_a;
          bf_b_r        <= bus.rd_data_b;
          bf_w_r        <= bus.tw_data;
          bf_valid_in_r <= 1'b1;
`ifdef BF_TIMEOUT_EN
          to_cnt_r      <= '0;
`endif
          state_r       <= EXEC;
        end
        EXEC: begin
          if (bus.bf_valid_out) begin
            wr_data_a_r   <= bus.bf_c;
            wr_data_b_r   <= bus.bf_d;
            wr_addr_a_r   <= rd_addr_a_r;
            wr_addr_b_r   <= rd_addr_b_r;
            bf_valid_in_r <= 1'b0;
            wr_en_r       <= 1'b1;
            state_r       <= WR;
`ifdef BF_TIMEOUT_EN
          end else if (to_cnt_r == TO_LAST) begin
            // butterfly never answered: abandon the transform without writing
            err_r         <= 1'b1;
            bf_valid_in_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
            state_r       <= DONE;
          end else begin
            to_cnt_r <= to_cnt_r + TOW'(1);
            state_r  <= EXEC;
          end
`else
          end else begin
            state_r <= EXEC;
          end
`endif
        end
        WR: begin
          if (last_j_s && last_s_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            s_r         <= s_nxt_s;
            j_r         <= j_nxt_s;
            rd_en_r     <= 1'b1;
            rd_addr_a_r <= addr_a_of(s_nxt_s, j_nxt_s);
            rd_addr_b_r <= addr_b_of(s_nxt_s, j_nxt_s);
            tw_addr_r   <= tw_of(s_nxt_s, j_nxt_s);
            state_r     <= RD;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          busy_r        <= 1'b0;
          bf_valid_in_r <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.rd_en       = rd_en_r;
  assign bus.rd_addr_a   = rd_addr_a_r;
  assign bus.rd_addr_b   = rd_addr_b_r;
  assign bus.tw_addr     = tw_addr_r;
  assign bus.bf_valid_in = bf_valid_in_r;
  assign bus.bf_a        = bf_a_r;
  assign bus.bf_b        = bf_b_r;
  assign bus.bf_w        = bf_w_r;
  assign bus.wr_en       = wr_en_r;
  assign bus.wr_addr_a   = wr_addr_a_r;
  assign bus.wr_addr_b   = wr_addr_b_r;
  assign bus.wr_data_a   = wr_data_a_r;
  assign bus.wr_data_b   = wr_data_b_r;
`ifdef BF_TIMEOUT_EN
  assign bus.err         = err_r;
`else
  assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_fft_butterfly_sched.sv
// tb_fft_butterfly_sched
//   Directed bench for fft_butterfly_sched at LOG2N=3.
//   Surrounds the DUT with:
//     - a sample RAM and twiddle ROM model
//     - a butterfly model using Q2.30 complex arithmetic, which agrees with
//       posit32 on the values 0 and +/-1.0 used for the impulse check
//     - scoreboard queues for read addresses and write results
module tb_fft_butterfly_sched;
  localparam int LOG2N = 3;
  localparam int N     = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_butterfly_sched_if #(.LOG2N(LOG2N)) bus ();
  fft_butterfly_sched #(.LOG2N(LOG2N), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct packed { logic [2:0] a; logic [2:0] b; logic [1:0] tw; } trip_t;
  typedef struct packed { logic [2:0] a; logic [2:0] b; logic [63:0] c; logic [63:0] d; } wr_t;
  trip_t exp_q[$];
  wr_t   wr_q[$];

  // twiddles W^k = exp(-2*pi*i*k/8) in Q2.30
  function automatic logic [63:0] tw_val(input int k);
    case (k)
      0:       return {32'h40000000, 32'h00000000};
      1:       return {32'h2D413CCD, 32'hD2BEC333};
      2:       return {32'h00000000, 32'hC0000000};
      3:       return {32'hD2BEC333, 32'hD2BEC333};
      default: return 64'd0;
    endcase
  endfunction

  // C = A + W*B (sub=0) or D = A - W*B (sub=1)
  function automatic logic [63:0] bfly(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] w, input bit sub);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    logic [31:0] cr, ci;
    ar = longint'($signed(a[63:32])); ai = longint'($signed(a[31:0]));
    br = longint'($signed(b[63:32])); bi = longint'($signed(b[31:0]));
    wr = longint'($signed(w[63:32])); wi = longint'($signed(w[31:0]));
    pr = (wr * br - wi * bi) >>> 30;
    pi = (wr * bi + wi * br) >>> 30;
    if (sub) begin
      cr = 32'(ar - pr); ci = 32'(ai - pi);
    end else begin
      cr = 32'(ar + pr); ci = 32'(ai + pi);
    end
    return {cr, ci};
  endfunction

  // sample RAM, twiddle ROM and preload
  logic [63:0] mem [N];
  int preload_mode = 0;
  always @(posedge clk) begin
    if (preload_mode == 1) begin
      for (int i = 0; i < N; i++) mem[i] <= {32'(i) << 24, 32'(i * 5) << 20};
    end else if (preload_mode == 2) begin
      for (int i = 0; i < N; i++) mem[i] <= (i == 0) ? {32'h40000000, 32'h00000000} : 64'd0;
    end
    if (bus.rd_en) begin
      bus.rd_data_a <= mem[bus.rd_addr_a];
      bus.rd_data_b <= mem[bus.rd_addr_b];
    end
    bus.tw_data <= tw_val(int'(bus.tw_addr));
    if (bus.wr_en) begin
      mem[bus.wr_addr_a] <= bus.wr_data_a;
      mem[bus.wr_addr_b] <= bus.wr_data_b;
    end
  end

  // butterfly model: result valid on the bf_hold-th cycle of bf_valid_in
  int bf_hold  = 1;
  bit bf_stuck = 1'b0;
  int exec_cnt = 0;
  always @(posedge clk) begin
    if (bus.bf_valid_in && !bus.bf_valid_out) exec_cnt <= exec_cnt + 1;
    else exec_cnt <= 0;
  end
  assign bus.bf_valid_out = bus.bf_valid_in && !bf_stuck && (exec_cnt >= bf_hold - 1);
  assign bus.bf_c = bfly(bus.bf_a, bus.bf_b, bus.bf_w, 1'b0);
  assign bus.bf_d = bfly(bus.bf_a, bus.bf_b, bus.bf_w, 1'b1);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expected (A,B,tw) sequence of the 8-point transform
  task automatic load_trace();
    int ta[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int tb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int tt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    exp_q.delete();
    for (int i = 0; i < 12; i++) exp_q.push_back('{a: 3'(ta[i]), b: 3'(tb[i]), tw: 2'(tt[i])});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {58'd0, bus.busy, bus.done, bus.err, bus.rd_en, bus.wr_en, bus.bf_valid_in}, 64'd0);
    chk({tag, "_addr"}, {49'd0, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b}, 64'd0);
    chk({tag, "_data"}, bus.bf_a | bus.bf_b | bus.bf_w | bus.wr_data_a | bus.wr_data_b, 64'd0);
  endtask

  // one transform: start pulse, then per-cycle scoreboard until done, reset or budget
  task automatic run_xform(input int budget, input int rst_at,
                           output int busy_n, output int done_at, output int wr_n,
                           output int exec_n, output int first_exec);
    trip_t t;
    wr_t   w;
    logic [63:0] ea, eb, ew, pa, pb, pw;
    logic [2:0]  cur_a, cur_b;
    bit in_exec_prev, excl, stop;
    busy_n = 0; done_at = -1; wr_n = 0; exec_n = 0; first_exec = -1;
    in_exec_prev = 1'b0; stop = 1'b0;
    ea = 64'd0; eb = 64'd0; ew = 64'd0; pa = 64'd0; pb = 64'd0; pw = 64'd0;
    cur_a = 3'd0; cur_b = 3'd0;
    wr_q.delete();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= budget && !stop; cyc++) begin
      if (cyc == 1) chk("err_cleared_by_start", {63'd0, bus.err}, 64'd0);
      if (cyc == 10) bus.start = 1'b1;
      if (cyc == 11) bus.start = 1'b0;
      excl = (bus.rd_en & bus.wr_en) | (bus.rd_en & bus.bf_valid_in) | (bus.wr_en & bus.bf_valid_in);
      chk("strobe_exclusive", {63'd0, excl}, 64'd0);
      if (bus.busy) busy_n++;
      if (bus.rd_en) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 64'd1, 64'd0);
        end else begin
          t = exp_q.pop_front();
          chk("rd_addr_a", 64'(bus.rd_addr_a), 64'(t.a));
          chk("rd_addr_b", 64'(bus.rd_addr_b), 64'(t.b));
          chk("tw_addr", 64'(bus.tw_addr), 64'(t.tw));
          ea = mem[t.a]; eb = mem[t.b]; ew = tw_val(int'(t.tw));
          cur_a = t.a; cur_b = t.b;
        end
      end
      if (bus.bf_valid_in) begin
        exec_n++;
        if (!in_exec_prev) begin
          if (first_exec < 0) first_exec = cyc;
          chk("bf_a", bus.bf_a, ea);
          chk("bf_b", bus.bf_b, eb);
          chk("bf_w", bus.bf_w, ew);
          wr_q.push_back('{a: cur_a, b: cur_b, c: bfly(ea, eb, ew, 1'b0), d: bfly(ea, eb, ew, 1'b1)});
        end else begin
          chk("bf_ops_stable", bus.bf_a ^ pa ^ bus.bf_b ^ pb ^ bus.bf_w ^ pw, 64'd0);
        end
        pa = bus.bf_a; pb = bus.bf_b; pw = bus.bf_w;
      end
      in_exec_prev = bus.bf_valid_in;
      if (bus.wr_en) begin
        wr_n++;
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr_a", 64'(bus.wr_addr_a), 64'(w.a));
          chk("wr_addr_b", 64'(bus.wr_addr_b), 64'(w.b));
          chk("wr_data_a", bus.wr_data_a, w.c);
          chk("wr_data_b", bus.wr_data_b, w.d);
        end
      end
      if (bus.done) begin
        done_at = cyc;
        chk("busy_low_at_done", {63'd0, bus.busy}, 64'd0);
        stop = 1'b1;
      end else if (cyc == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        stop = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!stop) chk("run_budget_expired", 64'd1, 64'd0);
  endtask

  int busy_n, done_at, wr_n, exec_n, fe;

  initial begin
    bus.start    = 1'b0;
    rst_n        = 1'b0;
    preload_mode = 1;
    repeat (2) @(negedge clk);
    preload_mode = 0;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {63'd0, bus.busy}, 64'd0);

    // zero-latency butterfly: timing, address trace, data scoreboard
    load_trace();
    run_xform(200, 0, busy_n, done_at, wr_n, exec_n, fe);
    chk("t1_busy_cycles", 64'(busy_n), 64'd48);
    chk("t1_done_cycle", 64'(done_at), 64'd49);
    chk("t1_writes", 64'(wr_n), 64'd12);
    chk("t1_trace_consumed", 64'(exp_q.size()), 64'd0);
    chk("t1_err", {63'd0, bus.err}, 64'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", {62'd0, bus.done, bus.busy}, 64'd0);

    // impulse at x[0] transforms to a flat spectrum of 1.0
    preload_mode = 2;
    @(negedge clk);
    preload_mode = 0;
    load_trace();
    run_xform(200, 0, busy_n, done_at, wr_n, exec_n, fe);
    @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("impulse_X%0d", i), mem[i], {32'h40000000, 32'h00000000});

    // five-cycle butterfly stretches EXEC
    bf_hold = 5;
    preload_mode = 1;
    @(negedge clk);
    preload_mode = 0;
    load_trace();
    run_xform(300, 0, busy_n, done_at, wr_n, exec_n, fe);
    chk("t4_busy_cycles", 64'(busy_n), 64'd96);
    chk("t4_done_cycle", 64'(done_at), 64'd97);
    chk("t4_exec_cycles", 64'(exec_n), 64'd60);
    chk("t4_writes", 64'(wr_n), 64'd12);
    bf_hold = 1;
    @(negedge clk);

    // reset mid-transform, then a clean restart
    load_trace();
    run_xform(200, 20, busy_n, done_at, wr_n, exec_n, fe);
    @(negedge clk);
    chk("post_reset_idle", {62'd0, bus.busy, bus.rd_en}, 64'd0);
    load_trace();
    run_xform(200, 0, busy_n, done_at, wr_n, exec_n, fe);
    chk("t5_busy_cycles", 64'(busy_n), 64'd48);
    chk("t5_done_cycle", 64'(done_at), 64'd49);
    @(negedge clk);

`ifdef BF_TIMEOUT_EN
    // stuck butterfly trips the watchdog
    bf_stuck = 1'b1;
    load_trace();
    run_xform(100, 0, busy_n, done_at, wr_n, exec_n, fe);
    chk("t6_done_after_exec", 64'(done_at), 64'(fe + 4));
    chk("t6_no_writes", 64'(wr_n), 64'd0);
    chk("t6_err_set", {63'd0, bus.err}, 64'd1);
    chk("t6_valid_dropped", {63'd0, bus.bf_valid_in}, 64'd0);
    @(negedge clk);
    chk("t6_err_sticky", {63'd0, bus.err}, 64'd1);
    bf_stuck = 1'b0;
    load_trace();
    run_xform(200, 0, busy_n, done_at, wr_n, exec_n, fe);
    chk("t6_recover_done", 64'(done_at), 64'd49);
    chk("t6_recover_err", {63'd0, bus.err}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
